ofm_tile_writer: RTL and testbench

OFM_TILE_WRITER -- requirements
Module: ofm_tile_writer

---
 rtl/ofm_tile_writer_pkg.sv | 17 +
 rtl/ofm_addr_gen.sv | 133 +++++++++++++
 rtl/ofm_tile_writer.sv | 145 ++++++++++++++
 tb/tb_ofm_tile_writer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_tile_writer_pkg.sv
// Shared types and helpers for the output-feature-map tile writer.
package ofm_tile_writer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DATA_W_DEF = 25;
  localparam int unsigned CH_W       = 6;

  // Channel count for a layer: (cfg+1)*8, at most 32.
  function automatic logic [CH_W-1:0] ch_count(input logic [1:0] cfg);
    return ({4'd0, cfg} + 6'd1) << 3;
  endfunction

endpackage

// File: rtl/ofm_addr_gen.sv
// Tiling counter chain (ow / row-in-band / tile / band / ch) producing the
// linear write address from incrementing base registers.
module ofm_addr_gen
  import ofm_tile_writer_pkg::*;
#(
  parameter int unsigned TI      = 16,
  parameter int unsigned TILES_W = 4,
  parameter int unsigned BAND_H  = 5,
  parameter int unsigned OFM_H   = 65,
  parameter int unsigned ADDR_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic              dual_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_row_o,
  output logic              ch_end_o,
  output logic [CH_W-1:0]   ch_o
);

  localparam int unsigned OFM_W  = TI * TILES_W;
  localparam int unsigned BANDS  = OFM_H / BAND_H;
  localparam int unsigned OW_W   = $clog2(TI + 1);
  localparam int unsigned RIB_W  = $clog2(BAND_H + 2);
  localparam int unsigned TILE_W = $clog2(TILES_W + 1);
  localparam int unsigned BAND_W = $clog2(BANDS + 1);

  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(OFM_W);
  localparam logic [ADDR_W-1:0] ROW2_STEP = ADDR_W'(2 * OFM_W);
  localparam logic [ADDR_W-1:0] TILE_STEP = ADDR_W'(TI);
  localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(BAND_H * OFM_W);

  logic [OW_W-1:0]   ow_q, ow_d;
  logic [RIB_W-1:0]  rib_q, rib_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  // band_base tracks the first row of the current band; channels are
  // contiguous, so it simply keeps counting across channel boundaries.
  logic [ADDR_W-1:0] band_base_q, band_base_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] tile_off_q, tile_off_d;

  logic              ow_last, row_wrap, tile_last, band_last;
  logic [RIB_W-1:0]  rib_sum;

  assign ow_last   = (ow_q == OW_W'(TI - 1));
  assign rib_sum   = rib_q + (dual_i ? RIB_W'(2) : RIB_W'(1));
  assign row_wrap  = ow_last && (rib_sum >= RIB_W'(BAND_H));
  assign tile_last = (tile_q == TILE_W'(TILES_W - 1));
  assign band_last = (band_q == BAND_W'(BANDS - 1));

  assign addr_o     = row_base_q + tile_off_q + ADDR_W'(ow_q);
  assign last_row_o = (rib_q >= RIB_W'(BAND_H - 1));
  assign ch_end_o   = row_wrap && tile_last && band_last;
  assign ch_o       = ch_q;

  always_comb begin
    // NOTE: every _d gets its default first so no path leaves it unassigned (no latch).
    ow_d        = ow_q;
    rib_d       = rib_q;
    tile_d      = tile_q;
    band_d      = band_q;
    ch_d        = ch_q;
    band_base_d = band_base_q;
    row_base_d  = row_base_q;
    tile_off_d  = tile_off_q;
    if (clear_i) begin
      ow_d        = '0;
      rib_d       = '0;
      tile_d      = '0;
      band_d      = '0;
      ch_d        = '0;
      band_base_d = '0;
      row_base_d  = '0;
      tile_off_d  = '0;
    end else if (step_i) begin
      if (!ow_last) begin
        ow_d = ow_q + OW_W'(1);
      end else begin
        ow_d = '0;
        if (!row_wrap) begin
          rib_d      = rib_sum;
          row_base_d = row_base_q + (dual_i ? ROW2_STEP : ROW_STEP);
        end else begin
          rib_d = '0;
          if (!tile_last) begin
            tile_d     = tile_q + TILE_W'(1);
            tile_off_d = tile_off_q + TILE_STEP;
            row_base_d = band_base_q;
          end else begin
            tile_d      = '0;
            tile_off_d  = '0;
            band_base_d = band_base_q + BAND_STEP;
            row_base_d  = band_base_q + BAND_STEP;
            if (!band_last) begin
              band_d = band_q + BAND_W'(1);
            end else begin
              band_d = '0;
              ch_d   = ch_q + CH_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      ow_q        <= '0;
      rib_q       <= '0;
      tile_q      <= '0;
      band_q      <= '0;
      ch_q        <= '0;
      band_base_q <= '0;
      row_base_q  <= '0;
      tile_off_q  <= '0;
    end else begin
      ow_q        <= ow_d;
      rib_q       <= rib_d;
      tile_q      <= tile_d;
      band_q      <= band_d;
      ch_q        <= ch_d;
      band_base_q <= band_base_d;
      row_base_q  <= row_base_d;
      tile_off_q  <= tile_off_d;
    end
  end

endmodule

// File: rtl/ofm_tile_writer.sv
// Writes dual-row OFM sample streams into a linear buffer in ch/row/tile/ow order,
// with layer sequencing and a sticky protocol-error flag.
module ofm_tile_writer
  import ofm_tile_writer_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TI      = 16,
  parameter int unsigned TILES_W = 4,
  parameter int unsigned BAND_H  = 5,
  parameter int unsigned OFM_H   = 65,
  parameter int unsigned ADDR_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cfg_co,
  input  logic [DATA_W-1:0] ofm_port0,
  input  logic [DATA_W-1:0] ofm_port1,
  input  logic              ofm_port0_v,
  input  logic              ofm_port1_v,
  output logic              wr0_en,
  output logic              wr1_en,
  output logic [ADDR_W-1:0] wr0_addr,
  output logic [ADDR_W-1:0] wr1_addr,
  output logic [DATA_W-1:0] wr0_data,
  output logic [DATA_W-1:0] wr1_data,
  output logic              ch_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned OFM_W = TI * TILES_W;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   last_ch_q, last_ch_d;
  logic              err_q, err_d;

  logic              wr0_en_q, wr1_en_q, ch_done_q, done_q;
  logic [ADDR_W-1:0] wr0_addr_q, wr1_addr_q;
  logic [DATA_W-1:0] wr0_data_q, wr1_data_q;

  logic              in_idle, in_run, clear, step, last_write;
  logic [ADDR_W-1:0] addr;
  logic              last_row, ch_end;
  logic [CH_W-1:0]   ch;

  assign in_idle    = (state_q == ST_IDLE);
  assign in_run     = (state_q == ST_RUN);
  assign clear      = in_idle && start;
  assign step       = in_run && ofm_port0_v;
  assign last_write = step && ch_end && (ch == last_ch_q);

  ofm_addr_gen #(
    .TI      (TI),
    .TILES_W (TILES_W),
    .BAND_H  (BAND_H),
    .OFM_H   (OFM_H),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .step_i     (step),
    .dual_i     (ofm_port1_v),
    .addr_o     (addr),
    .last_row_o (last_row),
    .ch_end_o   (ch_end),
    .ch_o       (ch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)      state_d = ST_RUN;
      ST_RUN:  if (last_write) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = in_run;
  end

  // A dual on the band's last row would spill its second row past the band.
  always_comb begin
    err_d     = err_q;
    last_ch_d = last_ch_q;
    if (clear) begin
      err_d     = 1'b0;
      last_ch_d = ch_count(cfg_co) - CH_W'(1);
    end else if (in_idle && (ofm_port0_v || ofm_port1_v)) begin
      err_d = 1'b1;
    end else if (in_run && ((ofm_port1_v && !ofm_port0_v) ||
                            (step && ofm_port1_v && last_row))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      last_ch_q  <= '0;
      wr0_en_q   <= 1'b0;
      wr1_en_q   <= 1'b0;
      ch_done_q  <= 1'b0;
      done_q     <= 1'b0;
      wr0_addr_q <= '0;
      wr1_addr_q <= '0;
      wr0_data_q <= '0;
      wr1_data_q <= '0;
    end else begin
      err_q     <= err_d;
      last_ch_q <= last_ch_d;
      wr0_en_q  <= step;
      wr1_en_q  <= step && ofm_port1_v;
      ch_done_q <= step && ch_end;
      done_q    <= last_write;
      if (step) begin
        wr0_addr_q <= addr;
        wr0_data_q <= ofm_port0;
      end
      if (step && ofm_port1_v) begin
        wr1_addr_q <= addr + ADDR_W'(OFM_W);
        wr1_data_q <= ofm_port1;
      end
    end
  end

  assign wr0_en   = wr0_en_q;
  assign wr1_en   = wr1_en_q;
  assign wr0_addr = wr0_addr_q;
  assign wr1_addr = wr1_addr_q;
  assign wr0_data = wr0_data_q;
  assign wr1_data = wr1_data_q;
  assign ch_done  = ch_done_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ofm_tile_writer.sv
// Bench for ofm_tile_writer: a formula-level model predicts every output each
// cycle, and literal expectations pin the model at the key points of a layer.
module tb_ofm_tile_writer;

  localparam int DATA_W  = 25;
  localparam int TI      = 16;
  localparam int TILES_W = 4;
  localparam int BAND_H  = 5;
  localparam int OFM_H   = 65;
  localparam int ADDR_W  = 18;
  localparam int OFM_W   = TI * TILES_W;
  localparam int CH_SZ   = OFM_H * OFM_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        cfg_co;
  logic [DATA_W-1:0] ofm_port0, ofm_port1;
  logic              ofm_port0_v, ofm_port1_v;
  logic              wr0_en, wr1_en;
  logic [ADDR_W-1:0] wr0_addr, wr1_addr;
  logic [DATA_W-1:0] wr0_data, wr1_data;
  logic              ch_done, busy, done, err;

  ofm_tile_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_co      (cfg_co),
    .ofm_port0   (ofm_port0),
    .ofm_port1   (ofm_port1),
    .ofm_port0_v (ofm_port0_v),
    .ofm_port1_v (ofm_port1_v),
    .wr0_en      (wr0_en),
    .wr1_en      (wr1_en),
    .wr0_addr    (wr0_addr),
    .wr1_addr    (wr1_addr),
    .wr0_data    (wr0_data),
    .wr1_data    (wr1_data),
    .ch_done     (ch_done),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              en0;
    logic              en1;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic              chd;
    logic              dn;
    logic              bsy;
    logic              er;
  } obs_t;

  obs_t exp_o, nxt_o;
  int   m_run, m_err, m_nch, m_ch, m_band, m_tile, m_rib, m_ow;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s at %0t: got 0x%0h, need 0x%0h", name, $time, act, req);
    end
  endtask

  // Predicts the outputs registered by the next clock edge.
  task automatic model_step(input logic s, input logic [1:0] cfg, input logic v0,
                            input logic v1, input logic [DATA_W-1:0] x0,
                            input logic [DATA_W-1:0] x1);
    int addr;
    nxt_o     = exp_o;
    nxt_o.en0 = 1'b0;
    nxt_o.en1 = 1'b0;
    nxt_o.chd = 1'b0;
    nxt_o.dn  = 1'b0;
    if (m_run == 0) begin
      if (s) begin
        m_run = 1; m_err = 0; m_nch = (int'(cfg) + 1) * 8;
        m_ch = 0; m_band = 0; m_tile = 0; m_rib = 0; m_ow = 0;
      end else if (v0 || v1) begin
        m_err = 1;
      end
    end else if (v1 && !v0) begin
      m_err = 1;
    end else if (v0) begin
      addr = m_ch * CH_SZ + (m_band * BAND_H + m_rib) * OFM_W + m_tile * TI + m_ow;
      nxt_o.en0 = 1'b1;
      nxt_o.a0  = ADDR_W'(addr);
      nxt_o.d0  = x0;
      if (v1) begin
        nxt_o.en1 = 1'b1;
        nxt_o.a1  = ADDR_W'(addr + OFM_W);
        nxt_o.d1  = x1;
        if (m_rib + 2 > BAND_H) m_err = 1;
      end
      m_ow++;
      if (m_ow == TI) begin
        m_ow = 0;
        m_rib += v1 ? 2 : 1;
        if (m_rib >= BAND_H) begin
          m_rib = 0;
          m_tile++;
          if (m_tile == TILES_W) begin
            m_tile = 0;
            m_band++;
            if (m_band * BAND_H == OFM_H) begin
              m_band = 0;
              nxt_o.chd = 1'b1;
              m_ch++;
              if (m_ch == m_nch) begin
                nxt_o.dn = 1'b1;
                m_run = 0;
              end
            end
          end
        end
      end
    end
    nxt_o.bsy = (m_run != 0);
    nxt_o.er  = (m_err != 0);
  endtask

  task automatic cycle(input logic s, input logic [1:0] cfg, input logic v0, input logic v1,
                       input logic [DATA_W-1:0] x0, input logic [DATA_W-1:0] x1);
    start       = s;
    cfg_co      = cfg;
    ofm_port0_v = v0;
    ofm_port1_v = v1;
    ofm_port0   = x0;
    ofm_port1   = x1;
    model_step(s, cfg, v0, v1, x0, x1);
    @(posedge clk);
    #1;
    exp_o       = nxt_o;
    start       = 1'b0;
    ofm_port0_v = 1'b0;
    ofm_port1_v = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    ofm_port0_v = 1'b0;
    ofm_port1_v = 1'b0;
    m_run = 0; m_err = 0; m_nch = 0; m_ch = 0;
    m_band = 0; m_tile = 0; m_rib = 0; m_ow = 0;
    exp_o = '0;
    nxt_o = '0;
    #1;
    check("rst_wr0_en", wr0_en, 0);
    check("rst_wr1_en", wr1_en, 0);
    check("rst_wr0_addr", wr0_addr, 0);
    check("rst_wr1_addr", wr1_addr, 0);
    check("rst_wr0_data", wr0_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    check("rst_ch_done", ch_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_wr0_en", wr0_en, exp_o.en0);
      check("cyc_wr1_en", wr1_en, exp_o.en1);
      check("cyc_wr0_addr", wr0_addr, exp_o.a0);
      check("cyc_wr1_addr", wr1_addr, exp_o.a1);
      check("cyc_wr0_data", wr0_data, exp_o.d0);
      check("cyc_wr1_data", wr1_data, exp_o.d1);
      check("cyc_ch_done", ch_done, exp_o.chd);
      check("cyc_done", done, exp_o.dn);
      check("cyc_busy", busy, exp_o.bsy);
      check("cyc_err", err, exp_o.er);
    end
  end

  initial begin
    cfg_co    = 2'd0;
    ofm_port0 = '0;
    ofm_port1 = '0;
    do_reset();
    cmp_en = 1'b1;

    // Layer 1: 8 channels of single-row writes.
    cycle(1'b1, 2'd0, 1'b0, 1'b0, '0, '0);
    check("start_busy", busy, 1);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 25'd7, '0);
    check("first_wr0_en", wr0_en, 1);
    check("first_wr0_addr", wr0_addr, 0);
    check("first_wr0_data", wr0_data, 7);
    check("first_wr1_en", wr1_en, 0);
    for (int i = 2; i <= 8 * 4160; i++) begin
      if (i % 97 == 0) cycle(1'b0, 2'd0, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, 2'd0, 1'b1, 1'b0, DATA_W'(i * 5 + 3), DATA_W'(i));
      case (i)
        17:       check("w17_addr", wr0_addr, 64);
        81:       check("w81_addr", wr0_addr, 16);
        321:      check("w321_addr", wr0_addr, 320);
        4159:     check("w4159_ch_done", ch_done, 0);
        4160:     check("w4160_ch_done", ch_done, 1);
        4161:     check("w4161_addr", wr0_addr, 4160);
        8 * 4160: begin
          check("last_done", done, 1);
          check("last_ch_done", ch_done, 1);
          check("last_busy", busy, 0);
        end
        default: ;
      endcase
    end
    cycle(1'b0, 2'd0, 1'b0, 1'b0, '0, '0);
    check("post_done", done, 0);
    check("post_wr0_en", wr0_en, 0);

    // Layer 2: dual-row writes, ignored start, orphan port1 valid.
    cycle(1'b1, 2'd1, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 2'd0, 1'b1, 1'b1, 25'd11, 25'd22);
    check("dual_wr0_addr", wr0_addr, 0);
    check("dual_wr1_addr", wr1_addr, 64);
    check("dual_wr1_en", wr1_en, 1);
    check("dual_wr1_data", wr1_data, 22);
    for (int i = 1; i < 32; i++)
      cycle(1'b0, 2'd0, 1'b1, 1'b1, DATA_W'(100 + i), DATA_W'(200 + i));
    for (int i = 0; i < 16; i++)
      cycle(1'b0, 2'd0, 1'b1, 1'b0, DATA_W'(300 + i), '0);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 25'd55, '0);
    check("tile1_addr", wr0_addr, 16);
    cycle(1'b1, 2'd3, 1'b1, 1'b0, 25'd56, '0);
    check("run_start_addr", wr0_addr, 17);
    check("run_start_busy", busy, 1);
    check("run_start_err", err, 0);
    cycle(1'b0, 2'd0, 1'b0, 1'b1, '0, 25'd9);
    check("orphan_err", err, 1);
    check("orphan_wr0_en", wr0_en, 0);
    check("orphan_wr1_en", wr1_en, 0);
    for (int i = 0; i < 60; i++)
      cycle(1'b0, 2'd0, 1'b1, i[0], DATA_W'(400 + i), DATA_W'(500 + i));

    // Reset mid-layer, then valids with no start.
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 2'd0, 1'b1, i[0], 25'd5, 25'd6);
    check("idle_wr0_en", wr0_en, 0);
    check("idle_err", err, 1);
    check("idle_busy", busy, 0);

    // Layer 3: dual on the band's last row and a dual-driven band wrap.
    cycle(1'b1, 2'd0, 1'b0, 1'b0, '0, '0);
    check("start_clears_err", err, 0);
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 2'd0, 1'b1, 1'b1, DATA_W'(600 + i), DATA_W'(700 + i));
    check("rib4_err", err, 0);
    cycle(1'b0, 2'd0, 1'b1, 1'b1, 25'd1, 25'd2);
    check("ovf_err", err, 1);
    check("ovf_wr1_addr", wr1_addr, 320);
    for (int i = 0; i < 14; i++)
      cycle(1'b0, 2'd0, 1'b1, 1'b0, DATA_W'(800 + i), '0);
    cycle(1'b0, 2'd0, 1'b1, 1'b1, 25'd3, 25'd4);
    check("ovf_wrap_wr0_addr", wr0_addr, 271);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 25'd5, '0);
    check("ovf_wrap_tile1", wr0_addr, 16);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, '0, '0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
